// File: rtl/time_keeper_pkg.sv
// Shared definitions for the alarm-clock time datapath: BCD digit type,
// per-digit limits and small digit-stepping helpers.
package time_keeper_pkg;

    // One BCD digit; also used by the alarm-set register and comparator stage.
    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX       = 4'd5;
    localparam bcd_t MIN_TENS_MAX       = 4'd5;
    localparam bcd_t HOUR_TENS_MAX      = 4'd2;
    localparam bcd_t HOUR_UNIT_MAX_AT_2 = 4'd3;
    localparam bcd_t UNIT_MAX           = 4'd9;

    // Advance one digit, wrapping to zero after max_v.
    function automatic bcd_t bcd_step(input bcd_t d, input bcd_t max_v);
        bcd_t r;
        if (d >= max_v) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    // Advance the hour pair {tens, unit} modulo 24.
    function automatic logic [7:0] hour_step(input bcd_t tens, input bcd_t unit);
        logic [7:0] r;
        if ((tens == HOUR_TENS_MAX) && (unit == HOUR_UNIT_MAX_AT_2)) begin
            r = 8'h00;
        end else if (unit == UNIT_MAX) begin
            r = {tens + 4'd1, 4'd0};
        end else begin
            r = {tens, unit + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/time_keeper_tick_gen.sv
// Prescaler: counts system clocks and flags the cycle in which the count
// reaches its terminal value. The flag is consumed on that same edge by the
// time registers, so the count wrap and the time advance coincide.
module tick_gen #(
    parameter int CLK_DIV = 50000000,
    parameter int CNT_W   = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Terminal-count flag; suppressed while the prescaler is held clear.
    assign tick = (cnt_r == LAST) && !clear;

    // Prescaler counter: held at zero while cleared, wraps after LAST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/time_keeper.sv
// 24-hour HH:MM:SS time-of-day counter in six BCD digits, advanced by a
// 1 Hz tick from the prescaler, with a set mode for stepping minutes/hours.
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int CLK_DIV = 50000000,
    parameter int CNT_W   = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_time,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [3:0] seg_unit,
    output logic [3:0] seg_tens,
    output logic [3:0] min_unit,
    output logic [3:0] min_tens,
    output logic [3:0] hour_unit,
    output logic [3:0] hour_tens,
    output logic       sec_tick
);

    bcd_t seg_unit_r, seg_tens_r, min_unit_r, min_tens_r, hour_unit_r, hour_tens_r;
    bcd_t seg_unit_s, seg_tens_s, min_unit_s, min_tens_s, hour_unit_s, hour_tens_s;
    logic sec_tick_r;
    logic min_prev_r, hour_prev_r;
    logic tick_s;
    logic min_step_s, hour_step_s;
    logic seg_wrap_s, min_wrap_s;
    logic [7:0] hour_next_s;

    tick_gen #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (set_time),
        .tick  (tick_s)
    );

    // Button rising edges only count in set mode; prev registers track always.
    assign min_step_s  = set_time && inc_min  && !min_prev_r;
    assign hour_step_s = set_time && inc_hour && !hour_prev_r;

    assign seg_wrap_s  = (seg_unit_r == UNIT_MAX) && (seg_tens_r == SEC_TENS_MAX);
    assign min_wrap_s  = (min_unit_r == UNIT_MAX) && (min_tens_r == MIN_TENS_MAX);
    assign hour_next_s = hour_step(hour_tens_r, hour_unit_r);

    // Next-time computation: set-mode stepping or run-mode carry chain.
    always_comb begin
        seg_unit_s  = seg_unit_r;
        seg_tens_s  = seg_tens_r;
        min_unit_s  = min_unit_r;
        min_tens_s  = min_tens_r;
        hour_unit_s = hour_unit_r;
        hour_tens_s = hour_tens_r;
        if (set_time) begin
            seg_unit_s = 4'd0;
            seg_tens_s = 4'd0;
            if (min_step_s) begin
                // Minutes wrap 59 -> 00 without touching the hours.
                min_unit_s = bcd_step(min_unit_r, UNIT_MAX);
                min_tens_s = (min_unit_r == UNIT_MAX) ? bcd_step(min_tens_r, MIN_TENS_MAX)
                                                      : min_tens_r;
            end else begin
                min_unit_s = min_unit_r;
                min_tens_s = min_tens_r;
            end
            if (hour_step_s) begin
                hour_tens_s = hour_next_s[7:4];
                hour_unit_s = hour_next_s[3:0];
            end else begin
                hour_tens_s = hour_tens_r;
                hour_unit_s = hour_unit_r;
            end
        end else if (tick_s) begin
            seg_unit_s = bcd_step(seg_unit_r, UNIT_MAX);
            seg_tens_s = (seg_unit_r == UNIT_MAX) ? bcd_step(seg_tens_r, SEC_TENS_MAX)
                                                  : seg_tens_r;
            if (seg_wrap_s) begin
                min_unit_s = bcd_step(min_unit_r, UNIT_MAX);
                min_tens_s = (min_unit_r == UNIT_MAX) ? bcd_step(min_tens_r, MIN_TENS_MAX)
                                                      : min_tens_r;
            end else begin
                min_unit_s = min_unit_r;
                min_tens_s = min_tens_r;
            end
            if (seg_wrap_s && min_wrap_s) begin
                hour_tens_s = hour_next_s[7:4];
                hour_unit_s = hour_next_s[3:0];
            end else begin
                hour_tens_s = hour_tens_r;
                hour_unit_s = hour_unit_r;
            end
        end else begin
            seg_unit_s = seg_unit_r;
            seg_tens_s = seg_tens_r;
        end
    end

    // Time, tick and button-history registers; all digits update on one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_unit_r  <= 4'd0;
            seg_tens_r  <= 4'd0;
            min_unit_r  <= 4'd0;
            min_tens_r  <= 4'd0;
            hour_unit_r <= 4'd0;
            hour_tens_r <= 4'd0;
            sec_tick_r  <= 1'b0;
            min_prev_r  <= 1'b0;
            hour_prev_r <= 1'b0;
        end else begin
            seg_unit_r  <= seg_unit_s;
            seg_tens_r  <= seg_tens_s;
            min_unit_r  <= min_unit_s;
            min_tens_r  <= min_tens_s;
            hour_unit_r <= hour_unit_s;
            hour_tens_r <= hour_tens_s;
            sec_tick_r  <= tick_s;
            min_prev_r  <= inc_min;
            hour_prev_r <= inc_hour;
        end
    end

    assign seg_unit  = seg_unit_r;
    assign seg_tens  = seg_tens_r;
    assign min_unit  = min_unit_r;
    assign min_tens  = min_tens_r;
    assign hour_unit = hour_unit_r;
    assign hour_tens = hour_tens_r;
    assign sec_tick  = sec_tick_r;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with CLK_DIV=4: a vector table for the
// basic run/set behaviour plus hand-written carry, wrap and reset sequences.
module tb_time_keeper;

    logic       clk;
    logic       reset;
    logic       set_time;
    logic       inc_min;
    logic       inc_hour;
    logic [3:0] seg_unit, seg_tens, min_unit, min_tens, hour_unit, hour_tens;
    logic       sec_tick;

    int checks = 0;
    int errors = 0;

    time_keeper #(.CLK_DIV(4), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .set_time  (set_time),
        .inc_min   (inc_min),
        .inc_hour  (inc_hour),
        .seg_unit  (seg_unit),
        .seg_tens  (seg_tens),
        .min_unit  (min_unit),
        .min_tens  (min_tens),
        .hour_unit (hour_unit),
        .hour_tens (hour_tens),
        .sec_tick  (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        set_time;
        logic        inc_min;
        logic        inc_hour;
        logic [23:0] exp_time;
        logic        exp_tick;
    } vec_t;

    vec_t vecs[20];

    function automatic logic [23:0] now_time();
        return {hour_tens, hour_unit, min_tens, min_unit, seg_tens, seg_unit};
    endfunction

    task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_time = 1'b0;
        inc_min = 1'b0;
        inc_hour = 1'b0;
        clk_step();
        clk_step();
        clk_step();
        reset = 1'b0;
    endtask

    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) begin
            inc_min = 1'b1;
            clk_step();
            inc_min = 1'b0;
            clk_step();
        end
    endtask

    task automatic press_hour(input int n);
        for (int i = 0; i < n; i++) begin
            inc_hour = 1'b1;
            clk_step();
            inc_hour = 1'b0;
            clk_step();
        end
    endtask

    // Wait (bounded) for the next sec_tick pulse.
    task automatic wait_tick(input string nm);
        int n = 0;
        do begin
            clk_step();
            n++;
        end while (!sec_tick && n < 8);
        if (!sec_tick) check({nm, "_timeout"}, {23'd0, sec_tick}, 24'd1);
    endtask

    // One second in run mode: time must hold until the tick, then show exp,
    // and the tick must last a single cycle.
    task automatic run_second(input string nm, input logic [23:0] exp);
        logic [23:0] start;
        int n;
        start = now_time();
        n = 0;
        do begin
            clk_step();
            n++;
            if (!sec_tick) check({nm, "_hold"}, now_time(), start);
        end while (!sec_tick && n < 8);
        check({nm, "_tick"}, {23'd0, sec_tick}, 24'd1);
        check({nm, "_time"}, now_time(), exp);
        clk_step();
        check({nm, "_tick_single"}, {23'd0, sec_tick}, 24'd0);
        check({nm, "_time_after"}, now_time(), exp);
    endtask

    initial begin
        // set, min, hour, expected HHMMSS, expected tick
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 24'h000001, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 24'h000001, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 24'h000001, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 24'h000001, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 24'h000002, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 24'h000100, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 24'h000100, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 24'h000100, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 24'h010200, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 24'h010200, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 24'h010200, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 24'h010200, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 24'h010200, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 24'h010201, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 24'h020200, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 24'h020200, 1'b0};

        // Reset state and vector table.
        do_reset();
        check("reset_time", now_time(), 24'h000000);
        check("reset_tick", {23'd0, sec_tick}, 24'd0);
        for (int i = 0; i < 20; i++) begin
            set_time = vecs[i].set_time;
            inc_min  = vecs[i].inc_min;
            inc_hour = vecs[i].inc_hour;
            clk_step();
            check($sformatf("vec%0d_time", i), now_time(), vecs[i].exp_time);
            check($sformatf("vec%0d_tick", i), {23'd0, sec_tick}, {23'd0, vecs[i].exp_tick});
        end

        // Set stepping: 61 minute presses, held hour button, hour wrap.
        do_reset();
        set_time = 1'b1;
        press_min(61);
        check("min61", now_time(), 24'h000100);
        inc_hour = 1'b1;
        repeat (10) clk_step();
        inc_hour = 1'b0;
        clk_step();
        check("hour_held", now_time(), 24'h010100);
        press_hour(22);
        check("hour23", now_time(), 24'h230100);
        press_hour(1);
        check("hour_wrap", now_time(), 24'h000100);

        // Minute/second carry into the hour.
        press_min(58);
        check("set_0059", now_time(), 24'h005900);
        set_time = 1'b0;
        repeat (58) wait_tick("to_005958");
        check("at_005958", now_time(), 24'h005958);
        run_second("to_005959", 24'h005959);
        run_second("to_010000", 24'h010000);

        // Day wrap from 23:59:59.
        do_reset();
        set_time = 1'b1;
        press_hour(23);
        press_min(59);
        check("set_2359", now_time(), 24'h235900);
        set_time = 1'b0;
        repeat (59) wait_tick("to_235959");
        check("at_235959", now_time(), 24'h235959);
        run_second("day_wrap", 24'h000000);

        // Simultaneous steps at 09:59, then hour pulses in run mode.
        do_reset();
        set_time = 1'b1;
        press_hour(9);
        press_min(59);
        check("set_0959", now_time(), 24'h095900);
        inc_min = 1'b1;
        inc_hour = 1'b1;
        clk_step();
        inc_min = 1'b0;
        inc_hour = 1'b0;
        clk_step();
        check("both_steps", now_time(), 24'h100000);
        set_time = 1'b0;
        press_hour(2);
        check("run_hour_ignored", {16'd0, hour_tens, hour_unit}, 24'h000010);

        // Asynchronous reset between edges at 12:34:56.
        do_reset();
        set_time = 1'b1;
        press_hour(12);
        press_min(34);
        set_time = 1'b0;
        repeat (56) wait_tick("to_123456");
        check("at_123456", now_time(), 24'h123456);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_time", now_time(), 24'h000000);
        check("async_reset_tick", {23'd0, sec_tick}, 24'd0);
        clk_step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            check($sformatf("post_reset_wait%0d", i), {23'd0, sec_tick}, 24'd0);
        end
        clk_step();
        check("post_reset_tick", {23'd0, sec_tick}, 24'd1);
        check("post_reset_time", now_time(), 24'h000001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
